pll_reconfig_sequencer: RTL and testbench



---
 rtl/pll_reconfig_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pll_reconfig_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_sequencer.sv
// Avalon-MM sequencer that programs one PLL reconfig slave from a local op table.
// Define PLL_RECONFIG_STATUS_POLL_EN to poll status (address 1) after the start write.
module pll_reconfig_sequencer #(
    parameter int NUM_CH       = 2,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int TBL_DEPTH    = 16,
    parameter int MODE_ADDR    = 0,
    parameter int START_ADDR   = 2,
    parameter int TIMEOUT      = 65535,
    parameter int LOCK_HOLDOFF = 16,
    localparam int TBL_AW = $clog2(TBL_DEPTH),
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic                       tbl_wr_en,
    input  logic [TBL_AW-1:0]          tbl_wr_addr,
    input  logic [ADDR_W+DATA_W-1:0]   tbl_wr_data,
    input  logic                       start,
    input  logic [CH_W-1:0]            ch_sel,
    input  logic [TBL_AW:0]            num_ops,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [ADDR_W-1:0]          mgmt_address,
    output logic [DATA_W-1:0]          mgmt_writedata,
    output logic [NUM_CH-1:0]          mgmt_write,
    output logic [NUM_CH-1:0]          mgmt_read,
    input  logic [NUM_CH*DATA_W-1:0]   mgmt_readdata,
    input  logic [NUM_CH-1:0]          mgmt_waitrequest,
    input  logic [NUM_CH-1:0]          pll_locked
);

    localparam int TMR_MAX = (TIMEOUT > LOCK_HOLDOFF) ? TIMEOUT : LOCK_HOLDOFF;
    localparam int TMR_W   = $clog2(TMR_MAX + 2);

    typedef enum logic [2:0] {IDLE, MODE, PROG, STRT, POLL, HOLD, LOCK} state_t;

    state_t state, state_d;

    logic [ADDR_W+DATA_W-1:0] tbl [TBL_DEPTH];
    logic [ADDR_W+DATA_W-1:0] tbl_q;
    logic [CH_W-1:0]          ch;
    logic [TBL_AW:0]          ops, op_idx;
    logic [TMR_W-1:0]         tmr;
    logic                     stb, stb_d, lk_seen;
    logic                     sel_wait, locked, ch_ok, ops_left;
    logic                     xfer_done, tmr_exp, fail, finish;
    logic [1:0]               fail_code;
    logic                     unused_rd;

    assign unused_rd = ^mgmt_readdata;
    assign sel_wait  = mgmt_waitrequest[ch];
    assign locked    = pll_locked[ch];
    assign ch_ok     = 32'(ch_sel) < NUM_CH;
    assign ops_left  = op_idx != ops;
    assign xfer_done = stb && !sel_wait;
    assign tmr_exp   = tmr >= TMR_W'(TIMEOUT);

`ifdef PLL_RECONFIG_STATUS_POLL_EN
    logic [NUM_CH-1:0] status;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_status
        assign status[i] = mgmt_readdata[i*DATA_W];
    end
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_d;
    end

    always_comb begin
        state_d   = state;
        fail      = 1'b0;
        fail_code = 2'd0;
        finish    = 1'b0;
        unique case (state)
            IDLE: if (start && ch_ok) state_d = MODE;
            MODE: if (xfer_done) state_d = PROG;
            PROG: if (!stb && !ops_left) state_d = STRT;
`ifdef PLL_RECONFIG_STATUS_POLL_EN
            STRT: if (xfer_done) state_d = POLL;
            POLL: begin
                if (xfer_done && status[ch]) state_d = HOLD;
                else if (tmr_exp) begin
                    fail      = 1'b1;
                    fail_code = 2'd3;
                end
            end
`else
            STRT: if (xfer_done) state_d = HOLD;
`endif
            HOLD: if (32'(tmr) + 32'd1 >= 32'(LOCK_HOLDOFF)) state_d = LOCK;
            LOCK: begin
                if (locked && lk_seen) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end else if (tmr_exp) begin
                    fail      = 1'b1;
                    fail_code = 2'd2;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stb && sel_wait && tmr_exp) begin
            fail      = 1'b1;
            fail_code = 2'd3;
        end
        if (fail) state_d = IDLE;
        // A strobe always starts from low, guaranteeing a gap between transfers.
        stb_d = 1'b0;
        if (state == IDLE)
            stb_d = (state_d == MODE);
        else if (state_d == state && state inside {MODE, PROG, STRT, POLL})
            stb_d = stb ? !xfer_done : (state != PROG || ops_left);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            stb      <= 1'b0;
            ch       <= '0;
            ops      <= '0;
            op_idx   <= '0;
            tmr      <= '0;
            lk_seen  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
        end else begin
            stb     <= stb_d;
            done    <= 1'b0;
            lk_seen <= (state == LOCK) && locked;
            // Polling is bounded as a whole, so reads do not restart the timer.
            if (state == IDLE || state_d != state || (xfer_done && state != POLL))
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;
            if (state == PROG && xfer_done) op_idx <= op_idx + 1'b1;
            if (state == IDLE && start) begin
                error    <= !ch_ok;
                err_code <= ch_ok ? 2'd0 : 2'd1;
                if (ch_ok) begin
                    ch     <= ch_sel;
                    ops    <= (32'(num_ops) > TBL_DEPTH) ? (TBL_AW+1)'(TBL_DEPTH) : num_ops;
                    op_idx <= '0;
                    busy   <= 1'b1;
                end
            end
            if (fail) begin
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= fail_code;
            end
            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (tbl_wr_en && state == IDLE) tbl[tbl_wr_addr] <= tbl_wr_data;
        tbl_q <= tbl[op_idx[TBL_AW-1:0]];
    end

    always_comb begin
        mgmt_address   = '0;
        mgmt_writedata = '0;
        mgmt_write     = '0;
        mgmt_read      = '0;
        unique case (state)
            MODE: mgmt_address = ADDR_W'(MODE_ADDR);
            PROG: begin
                mgmt_address   = tbl_q[ADDR_W+DATA_W-1:DATA_W];
                mgmt_writedata = tbl_q[DATA_W-1:0];
            end
            STRT: begin
                mgmt_address   = ADDR_W'(START_ADDR);
                mgmt_writedata = DATA_W'(1);
            end
`ifdef PLL_RECONFIG_STATUS_POLL_EN
            POLL: mgmt_address = ADDR_W'(1);
`endif
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (stb && ch == CH_W'(i)) begin
                if (state == POLL) mgmt_read[i]  = 1'b1;
                else               mgmt_write[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench for pll_reconfig_sequencer: directed runs, queued expectations.
// Honours PLL_RECONFIG_STATUS_POLL_EN by expecting three status reads per run.
module tb_pll_reconfig_sequencer;

    localparam int NCH = 3;
    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int TD  = 16;
    localparam int TO  = 100;
    localparam int HO  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              tbl_wr_en;
    logic [3:0]        tbl_wr_addr;
    logic [AW+DW-1:0]  tbl_wr_data;
    logic              start;
    logic [1:0]        ch_sel;
    logic [4:0]        num_ops;
    logic              busy, done, error;
    logic [1:0]        err_code;
    logic [AW-1:0]     mgmt_address;
    logic [DW-1:0]     mgmt_writedata;
    logic [NCH-1:0]    mgmt_write, mgmt_read;
    logic [NCH*DW-1:0] mgmt_readdata;
    logic [NCH-1:0]    mgmt_waitrequest;
    logic [NCH-1:0]    pll_locked;

    always #5 clk = ~clk;

    pll_reconfig_sequencer #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TBL_DEPTH(TD),
        .MODE_ADDR(0), .START_ADDR(2), .TIMEOUT(TO), .LOCK_HOLDOFF(HO)
    ) dut (
        .clk_clk(clk), .reset_reset(reset),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .start(start), .ch_sel(ch_sel), .num_ops(num_ops),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked)
    );

    // kind: 0 write, 1 read, 2 done, 3 error; abt marks a transfer an abort may swallow
    typedef struct packed {
        logic [1:0]     kind;
        logic [NCH-1:0] stb;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [1:0]     code;
        logic           abt;
    } ev_t;

    ev_t         q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [AW-1:0] m_addr [TD];
    logic [DW-1:0] m_data [TD];
    int          wait_n = 0;
    int          wc = 0;
    int          rd_n = 0;
    bit          stuck = 0;
    bit          perr = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(logic [1:0] k, logic [NCH-1:0] s, logic [AW-1:0] a,
                                 logic [DW-1:0] d, logic [1:0] c, logic abt);
        ev_t e;
        e.kind = k; e.stb = s; e.addr = a; e.data = d; e.code = c; e.abt = abt;
        q.push_back(e);
    endfunction

    function automatic void push_seq(logic [NCH-1:0] s, int n, logic [1:0] endk, logic [1:0] c);
        push(2'd0, s, 6'd0, 32'd0, 2'd0, 1'b0);
        for (int i = 0; i < n; i++) push(2'd0, s, m_addr[i], m_data[i], 2'd0, 1'b0);
        push(2'd0, s, 6'd2, 32'd1, 2'd0, 1'b0);
`ifdef PLL_RECONFIG_STATUS_POLL_EN
        for (int i = 0; i < 3; i++) push(2'd1, s, 6'd1, 32'd0, 2'd0, 1'b0);
`endif
        push(endk, '0, '0, '0, c, 1'b0);
    endfunction

    function automatic void expect_ev(string name, logic [1:0] k, logic [1:0] c);
        ev_t e;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected event kind %0d code %0d", name, k, c);
            return;
        end
        e = q.pop_front();
        chk(name, {k, c}, {e.kind, e.code});
    endfunction

    // Slave model: waitrequest for wait_n cycles per transfer, status set on 3rd read.
    initial begin
        mgmt_waitrequest = '0;
        mgmt_readdata    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b0) begin
                wc = 0;
                mgmt_waitrequest = '0;
            end else if (stuck) begin
                mgmt_waitrequest = '1;
            end else if (|(mgmt_write | mgmt_read)) begin
                if (wc < wait_n) begin
                    mgmt_waitrequest = '1;
                    wc++;
                end else begin
                    mgmt_waitrequest = '0;
                    wc = 0;
                end
            end else begin
                mgmt_waitrequest = '0;
                wc = 0;
            end
            mgmt_readdata = {NCH{DW'(rd_n >= 2)}};
        end
    end

    // Monitor: every strobed cycle must match the head transfer; pops on completion.
    always @(negedge clk) begin
        logic [NCH-1:0] s;
        s = mgmt_write | mgmt_read;
        if (reset === 1'b0) begin
            if (|s) begin
                if (q.size() == 0 || q[0].kind[1]) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL xfer: unexpected strobe %b addr %0h", s, mgmt_address);
                end else begin
                    chk("xfer", {(|mgmt_read) ? 2'd1 : 2'd0, s, mgmt_address, mgmt_writedata},
                        {q[0].kind, q[0].stb, q[0].addr, q[0].data});
                    if ((s & mgmt_waitrequest) == '0) begin
                        void'(q.pop_front());
                        if (|mgmt_read) rd_n++;
                    end
                end
            end
            if (done === 1'b1) begin
                expect_ev("done", 2'd2, 2'd0);
                chk("done_busy", busy, 0);
            end
            if (error === 1'b1 && !perr) begin
                while (q.size() > 0 && q[0].abt) void'(q.pop_front());
                expect_ev("error", 2'd3, err_code);
                chk("err_quiet", {busy, s}, 0);
            end
        end
        perr = (error === 1'b1);
    end

    task automatic load(int idx, logic [AW-1:0] a, logic [DW-1:0] d);
        @(negedge clk);
        tbl_wr_en = 1'b1;
        tbl_wr_addr = 4'(idx);
        tbl_wr_data = {a, d};
        @(negedge clk);
        tbl_wr_en = 1'b0;
        m_addr[idx] = a;
        m_data[idx] = d;
    endtask

    task automatic pulse_start(logic [1:0] ch, logic [4:0] n);
        @(negedge clk);
        rd_n = 0;
        ch_sel = ch;
        num_ops = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(string name, int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: busy still high after %0d cycles", name, maxc);
        end
    endtask

    task automatic settle(string name);
        repeat (3) @(negedge clk);
        chk(name, q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        tbl_wr_en = 1'b0;
        tbl_wr_addr = '0;
        tbl_wr_data = '0;
        start = 1'b0;
        ch_sel = '0;
        num_ops = '0;
        pll_locked = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {busy, done, error, err_code}, 0);
        chk("rst_strobes", {mgmt_write, mgmt_read}, 0);
        chk("rst_bus", {mgmt_address, mgmt_writedata}, 0);
        reset = 1'b0;

        load(0, 6'd4, 32'h0404);
        load(1, 6'd3, 32'h0202);
        load(2, 6'd5, 32'h0001_0101);

        // Zero-wait run on ch1, lock rises 40 cycles after start
        push_seq(3'b010, 3, 2'd2, 2'd0);
        pulse_start(2'd1, 5'd3);
        repeat (40) @(negedge clk);
        chk("busy_before_lock", busy, 1);
        pll_locked = 3'b010;
        wait_idle("run1", 200);
        settle("run1_q");
        chk("run1_flags", {busy, error}, 0);
        pll_locked = '0;

        // Waitrequest 5 cycles per transfer; a table write while busy is dropped
        wait_n = 5;
        pll_locked = 3'b010;
        push_seq(3'b010, 3, 2'd2, 2'd0);
        pulse_start(2'd1, 5'd3);
        load(1, 6'd7, 32'hdead);
        m_addr[1] = 6'd3;
        m_data[1] = 32'h0202;
        wait_idle("run2", 400);
        settle("run2_q");
        chk("run2_flags", {busy, error}, 0);
        push_seq(3'b010, 3, 2'd2, 2'd0);
        pulse_start(2'd1, 5'd3);
        wait_idle("run2b", 400);
        settle("run2b_q");
        wait_n = 0;

        // Out-of-range channel
        push(2'd3, '0, '0, '0, 2'd1, 1'b0);
        pulse_start(2'd3, 5'd3);
        chk("badch", {error, err_code, busy}, {1'b1, 2'd1, 1'b0});
        settle("badch_q");

        // Lock never arrives, then a fresh start clears the error
        pll_locked = '0;
        push_seq(3'b010, 3, 2'd3, 2'd2);
        pulse_start(2'd1, 5'd3);
        wait_idle("locktmo", 400);
        settle("locktmo_q");
        chk("locktmo_flags", {error, err_code}, {1'b1, 2'd2});
        pll_locked = 3'b010;
        push_seq(3'b010, 3, 2'd2, 2'd0);
        pulse_start(2'd1, 5'd3);
        chk("restart_clr", {error, err_code, busy}, {1'b0, 2'd0, 1'b1});
        wait_idle("restart", 300);
        settle("restart_q");

        // num_ops = 0 on ch0 goes straight from mode to start
        pll_locked = 3'b001;
        push_seq(3'b001, 0, 2'd2, 2'd0);
        pulse_start(2'd0, 5'd0);
        wait_idle("noops", 300);
        settle("noops_q");

        // Waitrequest stuck on the mode write
        stuck = 1;
        push(2'd0, 3'b010, 6'd0, 32'd0, 2'd0, 1'b1);
        push(2'd3, '0, '0, '0, 2'd3, 1'b0);
        pulse_start(2'd1, 5'd3);
        n = 0;
        while (error !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("bustmo_window", (n >= TO - 1 && n <= TO + 3), 1);
        chk("bustmo_flags", {error, err_code, mgmt_write}, {1'b1, 2'd3, 3'b000});
        stuck = 0;
        settle("bustmo_q");

        // Reset while the first table write is stalled
        wait_n = 5;
        push(2'd0, 3'b010, 6'd0, 32'd0, 2'd0, 1'b0);
        push(2'd0, 3'b010, m_addr[0], m_data[0], 2'd0, 1'b1);
        pulse_start(2'd1, 5'd3);
        n = 0;
        while (!(mgmt_write == 3'b010 && mgmt_address == m_addr[0]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_prog_reached", mgmt_address, m_addr[0]);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid", {mgmt_write, mgmt_read, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_q", q.size(), 1);
        q.delete();
        repeat (5) @(negedge clk);
        chk("rst_mid_idle", {mgmt_write, busy, error}, 0);
        wait_n = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
